// File: rtl/pipe_hold_ctrl.sv
// Central hold/flush controller. It merges trap, jump, load-use and busy
// requests into one hold-flag code plus a PC redirect. Jumps and traps that
// arrive while the pipeline is frozen are parked in a single pending entry
// and replayed in the first cycle the freeze lifts.
module pipe_hold_ctrl #(
  parameter int ADDR_WIDTH     = 64,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jump_req_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                  trap_req_i,
  input  logic [ADDR_WIDTH-1:0] trap_addr_i,
  input  logic                  load_use_i,
  input  logic                  mem_busy_i,
  input  logic                  div_busy_i,
  output logic [2:0]            hold_flag_o,
  output logic                  pc_redirect_o,
  output logic [ADDR_WIDTH-1:0] pc_redirect_addr_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o,
  output logic                  timeout_o
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  localparam logic [2:0] FLAG_NONE       = 3'b000;
  localparam logic [2:0] FLAG_FLUSH_JUMP = 3'b001;
  localparam logic [2:0] FLAG_HOLD_FRONT = 3'b010;
  localparam logic [2:0] FLAG_FLUSH_TRAP = 3'b011;
  localparam logic [2:0] FLAG_HOLD_ALL   = 3'b100;

  logic [0:0]            state_q, state_d;
  logic                  pend_valid_q, pend_valid_d;
  logic                  pend_trap_q, pend_trap_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;

  logic busy;
  logic replay;

  assign busy   = mem_busy_i | div_busy_i;
  // A pending entry only exists while frozen; it fires on the release cycle.
  assign replay = (state_q == HOLD) && pend_valid_q;

  // Flag/redirect selection and next-state logic, all from current inputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    hold_flag_o        = FLAG_NONE;
    pc_redirect_o      = 1'b0;
    pc_redirect_addr_o = '0;
    state_d            = state_q;
    pend_valid_d       = pend_valid_q;
    pend_trap_d        = pend_trap_q;
    pend_addr_d        = pend_addr_q;

    if (busy) begin
      hold_flag_o = FLAG_HOLD_ALL;
      state_d     = HOLD;
      // A trap always wins the slot; a jump only claims an empty slot.
      if (trap_req_i) begin
        pend_valid_d = 1'b1;
        pend_trap_d  = 1'b1;
        pend_addr_d  = trap_addr_i;
      end else if (jump_req_i && !pend_valid_q) begin
        pend_valid_d = 1'b1;
        pend_trap_d  = 1'b0;
        pend_addr_d  = jump_addr_i;
      end
    end else begin
      state_d      = RUN;
      pend_valid_d = 1'b0;
      pend_trap_d  = 1'b0;
      if (trap_req_i) begin
        // A live trap beats anything deferred.
        hold_flag_o        = FLAG_FLUSH_TRAP;
        pc_redirect_o      = 1'b1;
        pc_redirect_addr_o = trap_addr_i;
      end else if (replay) begin
        hold_flag_o        = pend_trap_q ? FLAG_FLUSH_TRAP : FLAG_FLUSH_JUMP;
        pc_redirect_o      = 1'b1;
        pc_redirect_addr_o = pend_addr_q;
      end else if (jump_req_i) begin
        hold_flag_o        = FLAG_FLUSH_JUMP;
        pc_redirect_o      = 1'b1;
        pc_redirect_addr_o = jump_addr_i;
      end else if (load_use_i) begin
        hold_flag_o = FLAG_HOLD_FRONT;
      end
    end

    if (rst) begin
      hold_flag_o        = FLAG_NONE;
      pc_redirect_o      = 1'b0;
      pc_redirect_addr_o = '0;
    end
  end

  // Consecutive-busy counter, saturating at all-ones, cleared on any idle cycle.
  always_comb begin
    stall_cnt_d = '0;
    if (busy) begin
      stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  // State, pending entry and counter registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= RUN;
      pend_valid_q <= 1'b0;
      pend_trap_q  <= 1'b0;
      pend_addr_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_trap_q  <= pend_trap_d;
      pend_addr_q  <= pend_addr_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign timeout_o   = (stall_cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES));

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Self-checking bench for pipe_hold_ctrl: directed scenarios followed by
// random traffic, all compared against a behavioural model of the rules.
module tb_pipe_hold_ctrl;

  localparam int AW = 64;
  localparam int CW = 16;
  localparam int TO = 8;

  logic          clk;
  logic          rst;
  logic          jump_req_i;
  logic [AW-1:0] jump_addr_i;
  logic          trap_req_i;
  logic [AW-1:0] trap_addr_i;
  logic          load_use_i;
  logic          mem_busy_i;
  logic          div_busy_i;
  logic [2:0]    hold_flag_o;
  logic          pc_redirect_o;
  logic [AW-1:0] pc_redirect_addr_o;
  logic [CW-1:0] stall_cnt_o;
  logic          timeout_o;

  int checks = 0;
  int errors = 0;

  // Behavioural model: the deferred request and the length of the current stall.
  logic          m_pend_v;
  logic          m_pend_trap;
  logic [AW-1:0] m_pend_addr;
  int            m_stall;
  int            timeout_pulses;

  pipe_hold_ctrl #(
    .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .jump_req_i(jump_req_i), .jump_addr_i(jump_addr_i),
    .trap_req_i(trap_req_i), .trap_addr_i(trap_addr_i),
    .load_use_i(load_use_i), .mem_busy_i(mem_busy_i), .div_busy_i(div_busy_i),
    .hold_flag_o(hold_flag_o), .pc_redirect_o(pc_redirect_o),
    .pc_redirect_addr_o(pc_redirect_addr_o),
    .stall_cnt_o(stall_cnt_o), .timeout_o(timeout_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check outputs, then
  // advance the model to what the next rising edge commits.
  task automatic step(input logic r, input logic jr, input logic [AW-1:0] ja,
                      input logic tr, input logic [AW-1:0] ta,
                      input logic lu, input logic mb, input logic db);
    logic [2:0]    e_flag;
    logic [AW-1:0] e_addr;
    logic          busy;
    @(negedge clk);
    rst = r; jump_req_i = jr; jump_addr_i = ja; trap_req_i = tr;
    trap_addr_i = ta; load_use_i = lu; mem_busy_i = mb; div_busy_i = db;
    #1;
    busy   = mb | db;
    e_flag = 3'b000;
    e_addr = '0;
    if (r)               begin e_flag = 3'b000; end
    else if (busy)       begin e_flag = 3'b100; end
    else if (tr)         begin e_flag = 3'b011; e_addr = ta; end
    else if (m_pend_v)   begin e_flag = m_pend_trap ? 3'b011 : 3'b001; e_addr = m_pend_addr; end
    else if (jr)         begin e_flag = 3'b001; e_addr = ja; end
    else if (lu)         begin e_flag = 3'b010; end
    check("hold_flag", AW'(hold_flag_o), AW'(e_flag));
    check("pc_redirect", AW'(pc_redirect_o), AW'(e_flag == 3'b001 || e_flag == 3'b011));
    check("redirect_addr", pc_redirect_addr_o, e_addr);
    check("stall_cnt", AW'(stall_cnt_o), AW'(m_stall));
    check("timeout", AW'(timeout_o), AW'(m_stall == TO));
    if (timeout_o) timeout_pulses++;
    if (r) begin
      m_pend_v = 1'b0; m_stall = 0;
    end else if (busy) begin
      m_stall = (m_stall < (1 << CW) - 1) ? m_stall + 1 : m_stall;
      if (tr) begin
        m_pend_v = 1'b1; m_pend_trap = 1'b1; m_pend_addr = ta;
      end else if (jr && !m_pend_v) begin
        m_pend_v = 1'b1; m_pend_trap = 1'b0; m_pend_addr = ja;
      end
    end else begin
      m_pend_v = 1'b0; m_stall = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; jump_req_i = 0; jump_addr_i = '0; trap_req_i = 0; trap_addr_i = '0;
    load_use_i = 0; mem_busy_i = 0; div_busy_i = 0;
    m_pend_v = 0; m_pend_trap = 0; m_pend_addr = '0; m_stall = 0; timeout_pulses = 0;

    // Reset, then quiet cycles.
    step(1, 0, '0, 0, '0, 0, 0, 0);
    step(1, 0, '0, 0, '0, 0, 0, 0);
    idle(2);

    // Jump beats load-use; trap beats jump.
    step(0, 1, 64'h8000_0040, 0, '0, 1, 0, 0);
    step(0, 1, 64'h8000_0040, 1, 64'h8000_0100, 0, 0, 0);
    step(0, 0, '0, 0, '0, 1, 0, 0);

    // Deferred jump across a 3-cycle memory stall.
    step(0, 1, 64'h8000_0200, 0, '0, 0, 1, 0);
    step(0, 0, '0, 0, '0, 0, 1, 0);
    step(0, 0, '0, 0, '0, 0, 1, 0);
    idle(2);

    // Jump then trap during a divider stall: only the trap replays.
    step(0, 1, 64'hA0, 0, '0, 0, 0, 1);
    step(0, 0, '0, 0, '0, 0, 0, 1);
    step(0, 0, '0, 1, 64'hC0, 0, 0, 1);
    step(0, 1, 64'hE0, 0, '0, 1, 0, 1);
    idle(2);

    // Long stall exercising the watchdog.
    timeout_pulses = 0;
    for (int i = 0; i < 20; i++) step(0, 0, '0, 0, '0, 0, 1, 0);
    idle(2);
    check("timeout_pulse_count", AW'(timeout_pulses), AW'(1));

    // Pending jump discarded by reset while busy drops.
    step(0, 1, 64'h1234, 0, '0, 0, 1, 0);
    step(0, 0, '0, 0, '0, 0, 1, 0);
    step(1, 0, '0, 0, '0, 0, 0, 0);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [AW-1:0] ja, ta;
      ja = {$urandom, $urandom};
      ta = {$urandom, $urandom};
      step(($urandom_range(0, 60) == 0),
           ($urandom_range(0, 2) == 0), ja,
           ($urandom_range(0, 5) == 0), ta,
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
